extmem_dma: RTL and testbench
=============================

EXTMEM_DMA -- requirements
Module: extmem_dma

Interface
REQ-001 SHALL have parameter AW, default `ADDR_EXT_RAM, external memory address width.
REQ-002 SHALL have parameter DW, default `DATA_EXT_RAM, external memory word width.
REQ-003 SHALL have parameter LW, default 16, burst length width in words.
REQ-004 SHALL have parameter DEPTH, default 4, read buffer depth (power of 2, >=2).
REQ-005 clk  in  1  sole clock; all logic on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when both valid and ready are high.
REQ-009 cmd_write  in  1  1 = stream-to-memory write burst; 0 = memory-to-stream read burst.
REQ-010 cmd_addr  in  AW  burst start word address.
REQ-011 cmd_len  in  LW  burst length in words; 0 = no-op.
REQ-012 rdo_valid / rdo_ready / rdo_data[DW] / rdo_last  out/in/out/out  read output stream; last marks the final word.
REQ-013 wri_valid / wri_ready / wri_data[DW]  in/out/in  write input stream.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 done  out  1  one-cycle pulse at burst completion.
REQ-016 ext_re / ext_rd_addr[AW] / ext_rd_data[DW]  out/out/in  memory read port; data is valid in the cycle after the ext_re cycle.
REQ-017 ext_we / ext_wr_addr[AW] / ext_wr_data[DW]  out/out/out  memory write port; memory writes on the clk edge ending the ext_we cycle.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE; cmd_ready = (state==IDLE).
REQ-019 IDLE, on command handshake: SHALL latch addr and len; len==0 -> done in the next cycle, remain IDLE; else go to READ (cmd_write=0) or WRITE (cmd_write=1).
REQ-020 READ: SHALL assert ext_re, registered, with sequential addresses while issued<len and (buffer_count + in_flight) < DEPTH.
REQ-021 SHALL capture ext_rd_data into the FIFO exactly one cycle after each ext_re cycle, in issue order; no word dropped or duplicated.
REQ-022 rdo_valid = FIFO non-empty; rdo_data = FIFO head; pop on rdo_valid & rdo_ready; rdo_last high only with the len-th word.
REQ-023 READ -> IDLE in the cycle after the rdo_last handshake, with done=1 in that cycle.
REQ-024 WRITE: wri_ready = 1 while accepted<len; each wri handshake SHALL produce ext_we=1 in the next cycle, with ext_wr_addr = start+index and ext_wr_data = that word.
REQ-025 WRITE -> IDLE, with done=1, in the cycle the len-th ext_we is driven.
REQ-026 Addresses SHALL increment modulo 2^AW; 2^AW-1 wraps to 0.
REQ-027 ext_re and ext_we SHALL never be high in the same cycle; ext_we SHALL be zero in READ, ext_re zero in WRITE.
REQ-028 Outputs SHALL be held while rdo_valid & !rdo_ready (stable data, valid not withdrawn).
REQ-029 Sustained throughput SHALL be one word/cycle when the stream side never stalls.
REQ-030 Commands SHALL be ignored while busy; no queuing.

Reset
REQ-031 On rst_n low, state SHALL go to IDLE immediately. Counters, FIFO and in-flight tracking SHALL clear. busy, done, rdo_valid, rdo_last, wri_ready, ext_re and ext_we SHALL go to 0; addr/data outputs to 0.
REQ-032 cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-033 Read data returning after a mid-burst reset SHALL be discarded.

Verification (DW=16, AW=23)
REQ-034 Read addr=4194304, len=4, rdo_ready=1 -> ext_re in 4 consecutive cycles at 4194304..4194307; 4 rdo words in order; rdo_last on word 4; done one cycle later.
REQ-035 Read len=10, rdo_ready low after word 2 for 8 cycles -> ext_re stalls with <=4 words buffered or in flight; all 10 words delivered in order after release.
REQ-036 Write addr=7340032, len=3, data 0x0001/0x0002/0x0003, wri_valid gapped -> exactly 3 ext_we pulses at 7340032..7340034 with matching data; done on the third.
REQ-037 cmd_len=0 -> done the next cycle; no ext_re/ext_we; cmd_ready stays 1.
REQ-038 Read addr=8388607, len=2 -> ext_rd_addr 8388607 then 0.
REQ-039 rst_n low mid-read (word 3 of 8) -> all outputs 0; after release, a new len=2 read yields exactly 2 correct words.

Source files
------------

// File: rtl/extmem_dma.sv
// Single-channel DMA between a valid/ready word stream and a synchronous external
// RAM port. Read bursts go through a small prefetch FIFO. Write bursts forward each accepted word.
`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 23
`endif
`ifndef DATA_EXT_RAM
`define DATA_EXT_RAM 16
`endif

module extmem_dma #(
  parameter int AW    = `ADDR_EXT_RAM,
  parameter int DW    = `DATA_EXT_RAM,
  parameter int LW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          rdo_valid,
  input  logic          rdo_ready,
  output logic [DW-1:0] rdo_data,
  output logic          rdo_last,
  input  logic          wri_valid,
  output logic          wri_ready,
  input  logic [DW-1:0] wri_data,
  output logic          busy,
  output logic          done,
  output logic          ext_re,
  output logic [AW-1:0] ext_rd_addr,
  input  logic [DW-1:0] ext_rd_data,
  output logic          ext_we,
  output logic [AW-1:0] ext_wr_addr,
  output logic [DW-1:0] ext_wr_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t        state_r;
  logic [AW-1:0] addr_r;
  logic [LW-1:0] len_r, issued_r, accepted_r, popped_r;
  logic          ext_re_r, re_d1_r, ext_we_r, done_r, wri_ready_r;
  logic [AW-1:0] ext_rd_addr_r, ext_wr_addr_r;
  logic [DW-1:0] ext_wr_data_r;
  logic [DW-1:0] fifo_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW:0]   occ_s;
  logic          push_s, pop_s, can_issue_s, last_s;

  // Occupancy counts buffered words plus the two read-pipeline stages still in flight.
  always_comb begin
    occ_s       = {1'b0, count_r} + {{CW{1'b0}}, ext_re_r} + {{CW{1'b0}}, re_d1_r};
    push_s      = re_d1_r;
    last_s      = (popped_r == (len_r - LW'(1'b1)));
    pop_s       = 1'b0;
    can_issue_s = 1'b0;
    if (state_r == READ) begin
      pop_s       = (count_r != {CW{1'b0}}) && rdo_ready;
      can_issue_s = (issued_r < len_r) && (occ_s < DEPTH_C);
    end else begin
      pop_s       = 1'b0;
      can_issue_s = 1'b0;
    end
  end

  assign cmd_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign done        = done_r;
  assign rdo_valid   = (count_r != {CW{1'b0}});
  assign rdo_data    = fifo_mem_r[rd_ptr_r];
  assign rdo_last    = rdo_valid && last_s;
  assign wri_ready   = wri_ready_r;
  assign ext_re      = ext_re_r;
  assign ext_rd_addr = ext_rd_addr_r;
  assign ext_we      = ext_we_r;
  assign ext_wr_addr = ext_wr_addr_r;
  assign ext_wr_data = ext_wr_data_r;

  // Read prefetch FIFO: captures memory data one cycle after each issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem_r[i] <= {DW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= ext_rd_data;
        wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      if (push_s && !pop_s) count_r <= count_r + CW'(1'b1);
      else if (!push_s && pop_s) count_r <= count_r - CW'(1'b1);
    end
  end

  // Burst control FSM with registered memory-port and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      addr_r        <= {AW{1'b0}};
      len_r         <= {LW{1'b0}};
      issued_r      <= {LW{1'b0}};
      accepted_r    <= {LW{1'b0}};
      popped_r      <= {LW{1'b0}};
      ext_re_r      <= 1'b0;
      re_d1_r       <= 1'b0;
      ext_we_r      <= 1'b0;
      done_r        <= 1'b0;
      wri_ready_r   <= 1'b0;
      ext_rd_addr_r <= {AW{1'b0}};
      ext_wr_addr_r <= {AW{1'b0}};
      ext_wr_data_r <= {DW{1'b0}};
    end else begin
      done_r  <= 1'b0;
      re_d1_r <= ext_re_r;
      case (state_r)
        IDLE: begin
          ext_re_r    <= 1'b0;
          ext_we_r    <= 1'b0;
          wri_ready_r <= 1'b0;
          if (cmd_valid) begin
            addr_r     <= cmd_addr;
            len_r      <= cmd_len;
            issued_r   <= {LW{1'b0}};
            accepted_r <= {LW{1'b0}};
            popped_r   <= {LW{1'b0}};
            if (cmd_len == {LW{1'b0}}) begin
              done_r <= 1'b1;
            end else if (cmd_write) begin
              state_r     <= WRITE;
              wri_ready_r <= 1'b1;
            end else begin
              state_r <= READ;
            end
          end
        end
        READ: begin
          ext_we_r    <= 1'b0;
          wri_ready_r <= 1'b0;
          if (can_issue_s) begin
            ext_re_r      <= 1'b1;
            ext_rd_addr_r <= addr_r;
            addr_r        <= addr_r + AW'(1'b1);
            issued_r      <= issued_r + LW'(1'b1);
          end else begin
            ext_re_r <= 1'b0;
          end
          if (pop_s) begin
            popped_r <= popped_r + LW'(1'b1);
            if (last_s) begin
              state_r <= IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        WRITE: begin
          ext_re_r <= 1'b0;
          if (wri_valid && wri_ready_r) begin
            ext_we_r      <= 1'b1;
            ext_wr_addr_r <= addr_r;
            ext_wr_data_r <= wri_data;
            addr_r        <= addr_r + AW'(1'b1);
            accepted_r    <= accepted_r + LW'(1'b1);
            if ((accepted_r + LW'(1'b1)) == len_r) begin
              wri_ready_r <= 1'b0;
              state_r     <= IDLE;
              done_r      <= 1'b1;
            end
          end else begin
            ext_we_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          ext_re_r    <= 1'b0;
          ext_we_r    <= 1'b0;
          wri_ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_dma.sv
// Randomized bench for extmem_dma: behavioural memory plus a burst-level reference
// that predicts every streamed word, memory address, and done timing.
module tb_extmem_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [22:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        rdo_valid, rdo_ready, rdo_last;
  logic [15:0] rdo_data;
  logic        wri_valid, wri_ready;
  logic [15:0] wri_data;
  logic        busy, done;
  logic        ext_re, ext_we;
  logic [22:0] ext_rd_addr, ext_wr_addr;
  logic [15:0] ext_rd_data, ext_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  extmem_dma #(.AW(23), .DW(16), .LW(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rdo_valid(rdo_valid), .rdo_ready(rdo_ready), .rdo_data(rdo_data), .rdo_last(rdo_last),
    .wri_valid(wri_valid), .wri_ready(wri_ready), .wri_data(wri_data),
    .busy(busy), .done(done),
    .ext_re(ext_re), .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
    .ext_we(ext_we), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data)
  );

  always #5 clk = ~clk;

  // Memory content is a fixed function of the address.
  function automatic logic [15:0] mem_word(input logic [22:0] a);
    return a[15:0] ^ {a[22:16], 9'h000} ^ 16'h5A3C;
  endfunction

  function automatic logic [22:0] addr_at(input int base, input int i);
    return 23'((base + i) % 8388608);
  endfunction

  // Environment: memory with one-cycle read latency plus port activity logs.
  int unsigned cyc = 0, re_cnt = 0, we_cnt = 0, hs_cnt = 0;
  logic [22:0] re_addr [4096];
  int unsigned re_cyc  [4096];
  logic        both_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ext_re) begin
      ext_rd_data          <= mem_word(ext_rd_addr);
      re_addr[re_cnt % 4096] <= ext_rd_addr;
      re_cyc[re_cnt % 4096]  <= cyc;
      re_cnt               <= re_cnt + 1;
    end
    if (ext_we) we_cnt <= we_cnt + 1;
    if (rdo_valid && rdo_ready) hs_cnt <= hs_cnt + 1;
    if (ext_re && ext_we) both_seen <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},      32'(busy), 32'd0);
    check_eq({tag, "_done"},      32'(done), 32'd0);
    check_eq({tag, "_rdo_valid"}, 32'(rdo_valid), 32'd0);
    check_eq({tag, "_rdo_last"},  32'(rdo_last), 32'd0);
    check_eq({tag, "_rdo_data"},  32'(rdo_data), 32'd0);
    check_eq({tag, "_wri_ready"}, 32'(wri_ready), 32'd0);
    check_eq({tag, "_ext_re"},    32'(ext_re), 32'd0);
    check_eq({tag, "_ext_we"},    32'(ext_we), 32'd0);
    check_eq({tag, "_rd_addr"},   32'(ext_rd_addr), 32'd0);
    check_eq({tag, "_wr_addr"},   32'(ext_wr_addr), 32'd0);
    check_eq({tag, "_wr_data"},   32'(ext_wr_data), 32'd0);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue_cmd(input logic wr, input logic [22:0] a, input logic [15:0] l);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_bogus_cmd(input int mode);
    if (mode == 1 && ($urandom % 4) == 0) begin
      check_eq("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 23'($urandom); cmd_len = 16'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: random ready + bogus commands, 2: stall 8 cycles after word 2.
  task automatic run_read(input logic [22:0] addr, input int len, input int mode, input int abort_at);
    int unsigned re0, we0, hs0, maxo, outst;
    int k = 0, n = 0, stalled = 0;
    logic r, prev_wait = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    re0 = re_cnt; we0 = we_cnt; hs0 = hs_cnt; maxo = 0;
    issue_cmd(1'b0, addr, 16'(len));
    while (k < len && n < 3000) begin
      outst = (re_cnt - re0) - (hs_cnt - hs0);
      if (outst > maxo) maxo = outst;
      if (prev_wait) begin
        check_eq("hold_valid", 32'(rdo_valid), 32'd1);
        check_eq("hold_data", 32'(rdo_data), 32'(prev_data));
      end
      if (abort_at != 0 && k == abort_at) begin
        rst_n = 1'b0; rdo_ready = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        return;
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 2 && k >= 2 && stalled < 8) begin r = 1'b0; stalled++; end
      else if (mode == 2) r = 1'b1;
      else r = (($urandom % 3) != 0);
      rdo_ready = r;
      drive_bogus_cmd(mode);
      if (rdo_valid && r) begin
        check_eq("rd_data", 32'(rdo_data), 32'(mem_word(addr_at(int'(addr), k))));
        check_eq("rd_last", 32'(rdo_last), 32'(k == len - 1));
        k++;
      end
      prev_wait = rdo_valid && !r;
      prev_data = rdo_data;
      @(posedge clk); #1; n++;
    end
    rdo_ready = 1'b0; cmd_valid = 1'b0;
    check_eq("rd_words", k, len);
    check_eq("rd_done", 32'(done), 32'd1);
    check_eq("rd_idle", 32'(busy), 32'd0);
    check_eq("rd_no_extra", 32'(rdo_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("rd_done_pulse", 32'(done), 32'd0);
    check_eq("rd_re_count", re_cnt - re0, len);
    check_eq("rd_no_we", we_cnt - we0, 32'd0);
    check_eq("rd_max_outstanding", 32'(maxo <= 4), 32'd1);
    for (int i = 0; i < len; i++)
      check_eq("rd_addr", 32'(re_addr[(re0 + i) % 4096]), 32'(addr_at(int'(addr), i)));
    if (mode == 0)
      check_eq("rd_consecutive", re_cyc[(re0 + len - 1) % 4096] - re_cyc[re0 % 4096], len - 1);
  endtask

  // mode 0: valid every cycle, 1: random valid/data + bogus commands, 2: data i+1, valid every other cycle.
  task automatic run_write(input logic [22:0] addr, input int len, input int mode);
    logic [15:0] dq[$];
    int unsigned re0, we0;
    int k = 0, n = 0;
    logic v, hs;
    re0 = re_cnt; we0 = we_cnt;
    for (int i = 0; i < len; i++) dq.push_back(mode == 2 ? 16'(i + 1) : 16'($urandom));
    issue_cmd(1'b1, addr, 16'(len));
    while (k < len && n < 3000) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 2) v = (n % 2) == 1;
      else v = 1'($urandom);
      wri_valid = v;
      wri_data  = v ? dq[k] : 16'($urandom);
      hs = v && wri_ready;
      drive_bogus_cmd(mode);
      @(posedge clk); #1; n++;
      if (hs) begin
        check_eq("wr_we", 32'(ext_we), 32'd1);
        check_eq("wr_addr", 32'(ext_wr_addr), 32'(addr_at(int'(addr), k)));
        check_eq("wr_data", 32'(ext_wr_data), 32'(dq[k]));
        check_eq("wr_done", 32'(done), 32'(k == len - 1));
        k++;
      end else begin
        check_eq("wr_we_idle", 32'(ext_we), 32'd0);
      end
    end
    wri_valid = 1'b0; cmd_valid = 1'b0;
    check_eq("wr_words", k, len);
    check_eq("wr_idle", 32'(busy), 32'd0);
    check_eq("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check_eq("wr_done_pulse", 32'(done), 32'd0);
    check_eq("wr_we_after", 32'(ext_we), 32'd0);
    check_eq("wr_we_count", we_cnt - we0, len);
    check_eq("wr_no_re", re_cnt - re0, 32'd0);
  endtask

  task automatic run_zero(input logic [22:0] addr, input logic wr);
    int unsigned re0, we0;
    re0 = re_cnt; we0 = we_cnt;
    issue_cmd(wr, addr, 16'h0000);
    check_eq("len0_done", 32'(done), 32'd1);
    check_eq("len0_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("len0_ready_hold", 32'(cmd_ready), 32'd1);
      check_eq("len0_done_clear", 32'(done), 32'd0);
    end
    check_eq("len0_no_re", re_cnt - re0, 32'd0);
    check_eq("len0_no_we", we_cnt - we0, 32'd0);
  endtask

  initial begin
    logic wr;
    logic [22:0] a;
    int l;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 23'h0; cmd_len = 16'h0;
    rdo_ready = 1'b0; wri_valid = 1'b0; wri_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("cmd_ready_first", 32'(cmd_ready), 32'd1);

    run_read(23'd4194304, 4, 0, 0);
    run_read(23'($urandom), 10, 2, 0);
    run_write(23'd7340032, 3, 2);
    run_zero(23'd1234, 1'b0);
    run_read(23'd8388607, 2, 0, 0);
    run_write(23'd8388606, 4, 0);
    run_read(23'd100, 8, 0, 2);
    run_read(23'd200, 2, 0, 0);

    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom);
      a  = (($urandom % 4) == 0) ? addr_at(8388607, -int'($urandom % 6)) : 23'($urandom);
      l  = int'($urandom_range(0, 12));
      if (l == 0) run_zero(a, wr);
      else if (wr) run_write(a, l, 1);
      else run_read(a, l, 1, 0);
    end

    check_eq("re_we_exclusive", 32'(both_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
